// File: rtl/bcd_mod_counter_if.sv
// bcd_mod_counter_if: control and data bundle for a packed-BCD modulo counter.
// Revision 1.0
`default_nettype none

interface bcd_mod_counter_if #(
  parameter int DIGITS = 2
) ();
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic                  en;
  logic                  up;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  load_err;

  modport master (
    output load, data, en, up,
    input  count, tc, load_err
  );

  modport slave (
    input  load, data, en, up,
    output count, tc, load_err
  );
endinterface

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: up/down packed-BCD counter modulo MODULUS with checked load
// and a combinational terminal count for cascading. Revision 1.0
`default_nettype none

module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 24
) (
  input  wire logic            clk,
  input  wire logic            reset,
  bcd_mod_counter_if.slave     bus
);
  localparam int W = 4 * DIGITS;

  function automatic logic [15:0] to_bcd(input int value);
    int v;
    v      = value;
    to_bcd = '0;
    for (int i = 0; i < 4; i++) begin
      to_bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  localparam logic [15:0]  MAX_BCD16 = to_bcd(MODULUS - 1);
  localparam logic [W-1:0] MAX_BCD   = MAX_BCD16[W-1:0];

  logic [W-1:0]      count_reg;
  logic              load_err_reg;
  logic [W-1:0]      inc_val;
  logic [W-1:0]      dec_val;
  logic              inc_carry;
  logic              dec_borrow;
  logic [DIGITS-1:0] digit_ok;
  logic              data_ok;
  logic              at_max;
  logic              at_zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign digit_ok[g] = (bus.data[4*g +: 4] <= 4'd9);
  end

  // Valid BCD orders the same as its binary value, so comparing against the
  // BCD constant is equivalent to data < MODULUS.
  assign data_ok = (&digit_ok) && (bus.data <= MAX_BCD);
  assign at_max  = (count_reg == MAX_BCD);
  assign at_zero = (count_reg == '0);

  always_comb begin
    inc_val    = count_reg;
    dec_val    = count_reg;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (count_reg[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_reg[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (count_reg[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_reg[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg    <= '0;
      load_err_reg <= 1'b0;
    end else if (bus.load) begin
      if (data_ok) begin
        count_reg    <= bus.data;
        load_err_reg <= 1'b0;
      end else begin
        load_err_reg <= 1'b1;
      end
    end else begin
      load_err_reg <= 1'b0;
      if (bus.en) begin
        if (bus.up) begin
          count_reg <= at_max ? '0 : inc_val;
        end else begin
          count_reg <= at_zero ? MAX_BCD : dec_val;
        end
      end
    end
  end

  // Unregistered so a following stage can use it directly as its enable.
  assign bus.tc       = bus.en & ((bus.up & at_max) | (~bus.up & at_zero));
  assign bus.count    = count_reg;
  assign bus.load_err = load_err_reg;
endmodule

`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: scoreboard bench for bcd_mod_counter (2-digit mod 24,
// a cascaded mod 60 / mod 24 pair, and a 3-digit mod 1000 instance).
`default_nettype none

module tb_bcd_mod_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b, reset_c;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    logic [15:0] count;
    logic        err;
  } exp_t;

  exp_t        sb_a[$];
  logic [15:0] sb_x[$];

  bcd_mod_counter_if #(.DIGITS(2)) bus_a ();
  bcd_mod_counter_if #(.DIGITS(2)) bus_l ();
  bcd_mod_counter_if #(.DIGITS(2)) bus_h ();
  bcd_mod_counter_if #(.DIGITS(3)) bus_c ();

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24))   dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(60))   dut_l (.clk(clk), .reset(reset_b), .bus(bus_l));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(24))   dut_h (.clk(clk), .reset(reset_b), .bus(bus_h));
  bcd_mod_counter #(.DIGITS(3), .MODULUS(1000)) dut_c (.clk(clk), .reset(reset_c), .bus(bus_c));

  assign bus_h.en = bus_l.tc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic bit bcd_valid(input logic [15:0] b);
    for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] int2bcd(input int value);
    logic [15:0] r;
    int v;
    v = value;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  int model_a    = 0;
  bit model_live = 1'b0;

  task automatic step_a(input bit rst, input bit ld, input logic [7:0] d,
                        input bit e, input bit u, input string tag);
    exp_t x;
    bit   exp_tc;
    bit   err;
    reset_a    = rst;
    bus_a.load = ld;
    bus_a.data = d;
    bus_a.en   = e;
    bus_a.up   = u;
    #1;
    if (model_live) begin
      exp_tc = e & ((u & (model_a == 23)) | (!u & (model_a == 0)));
      check({tag, "_tc"}, 32'(bus_a.tc), 32'(exp_tc));
    end
    err = 1'b0;
    if (rst) begin
      model_a = 0;
    end else if (ld) begin
      if (bcd_valid({8'h00, d}) && bcd2int({8'h00, d}) < 24) model_a = bcd2int({8'h00, d});
      else err = 1'b1;
    end else if (e) begin
      model_a = u ? (model_a + 1) % 24 : (model_a + 23) % 24;
    end
    if (rst) model_live = 1'b1;
    x.count = int2bcd(model_a);
    x.err   = err;
    sb_a.push_back(x);
    @(posedge clk);
    #1;
    x = sb_a.pop_front();
    check({tag, "_count"}, 32'(bus_a.count), 32'(x.count));
    check({tag, "_err"}, 32'(bus_a.load_err), 32'(x.err));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] e16;
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    bus_a.load = 1'b0; bus_a.data = '0; bus_a.en = 1'b0; bus_a.up = 1'b1;
    bus_l.load = 1'b0; bus_l.data = '0; bus_l.en = 1'b0; bus_l.up = 1'b1;
    bus_h.load = 1'b0; bus_h.data = '0; bus_h.up = 1'b1;
    bus_c.load = 1'b0; bus_c.data = '0; bus_c.en = 1'b0; bus_c.up = 1'b1;

    step_a(1, 0, 8'h00, 0, 1, "reset");
    step_a(1, 1, 8'h07, 1, 1, "reset_over_load");

    // From reset count is 0: tc follows en & ~up and flips with up mid-cycle.
    reset_a = 1'b0; bus_a.en = 1'b1; bus_a.up = 1'b1;
    #1 check("tc_up_at_zero", 32'(bus_a.tc), 32'd0);
    bus_a.up = 1'b0;
    #1 check("tc_down_at_zero", 32'(bus_a.tc), 32'd1);

    for (int i = 0; i < 25; i++) step_a(0, 0, 8'h00, 1, 1, "inc");
    step_a(0, 0, 8'h00, 0, 1, "hold");

    step_a(1, 0, 8'h00, 0, 0, "reset2");
    for (int i = 0; i < 6; i++) step_a(0, 0, 8'h00, 1, 0, "dec");

    step_a(0, 1, 8'h15, 0, 1, "load_15");
    step_a(0, 1, 8'h24, 0, 1, "load_24_rej");
    step_a(0, 0, 8'h00, 0, 1, "after_rej1");
    step_a(0, 1, 8'h1A, 1, 1, "load_1a_rej");
    step_a(0, 0, 8'h00, 0, 1, "after_rej2");
    step_a(0, 1, 8'h23, 0, 1, "load_23");
    step_a(0, 1, 8'h12, 0, 1, "load_12");
    step_a(0, 1, 8'h07, 1, 1, "load_beats_en");

    for (int i = 0; i < 60; i++) begin
      d[7:4] = 4'($urandom_range(0, 3));
      d[3:0] = 4'($urandom_range(0, 11));
      step_a(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0), d,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    // Cascade: mod-60 low stage feeds the mod-24 high stage through tc.
    cyc();
    reset_b = 1'b0;
    bus_l.load = 1'b1; bus_l.data = 8'h59;
    bus_h.load = 1'b1; bus_h.data = 8'h23;
    sb_x.push_back(16'h2359);
    cyc();
    e16 = sb_x.pop_front();
    check("casc_load", 32'({bus_h.count, bus_l.count}), 32'(e16));
    bus_l.load = 1'b0; bus_h.load = 1'b0; bus_l.en = 1'b1;
    #1;
    check("casc_tc_low", 32'(bus_l.tc), 32'd1);
    check("casc_tc_high", 32'(bus_h.tc), 32'd1);
    sb_x.push_back(16'h0000);
    sb_x.push_back(16'h0001);
    cyc();
    e16 = sb_x.pop_front();
    check("casc_wrap", 32'({bus_h.count, bus_l.count}), 32'(e16));
    cyc();
    e16 = sb_x.pop_front();
    check("casc_next", 32'({bus_h.count, bus_l.count}), 32'(e16));

    // Three digits, modulus 1000: full-width carry and borrow ripple.
    reset_c = 1'b0;
    bus_c.load = 1'b1; bus_c.data = 12'h999;
    sb_x.push_back(16'h0999);
    cyc();
    e16 = sb_x.pop_front();
    check("d3_load_999", 32'(bus_c.count), 32'(e16));
    bus_c.load = 1'b0; bus_c.en = 1'b1; bus_c.up = 1'b1;
    #1 check("d3_tc_999", 32'(bus_c.tc), 32'd1);
    sb_x.push_back(16'h0000);
    cyc();
    e16 = sb_x.pop_front();
    check("d3_inc_wrap", 32'(bus_c.count), 32'(e16));
    bus_c.en = 1'b0; bus_c.load = 1'b1; bus_c.data = 12'h100;
    sb_x.push_back(16'h0100);
    cyc();
    e16 = sb_x.pop_front();
    check("d3_load_100", 32'(bus_c.count), 32'(e16));
    bus_c.load = 1'b0; bus_c.en = 1'b1; bus_c.up = 1'b0;
    sb_x.push_back(16'h0099);
    cyc();
    e16 = sb_x.pop_front();
    check("d3_dec_borrow", 32'(bus_c.count), 32'(e16));
    bus_c.en = 1'b0; bus_c.load = 1'b1; bus_c.data = 12'h9A9;
    sb_x.push_back(16'h0099);
    cyc();
    e16 = sb_x.pop_front();
    check("d3_rej_count", 32'(bus_c.count), 32'(e16));
    check("d3_rej_err", 32'(bus_c.load_err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

`default_nettype wire

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 SHALL provide parameter DIGITS, default 2: number of packed BCD digits, legal range 1..4.
REQ-002 SHALL provide parameter MODULUS, default 24: count modulus, legal range 2..10^DIGITS.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset; synchronous, active-high.
REQ-005 SHALL have port load, input, 1 bit: load request for data.
REQ-006 SHALL have port data, input, 4*DIGITS bits: packed BCD load value; digit 0 in [3:0].
REQ-007 SHALL have port en, input, 1 bit: count enable; advances count by one step.
REQ-008 SHALL have port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-009 SHALL have port count, output, 4*DIGITS bits: registered packed BCD count value.
REQ-010 SHALL have port tc, output, 1 bit: combinational terminal-count / cascade carry.
REQ-011 SHALL have port load_err, output, 1 bit: registered one-cycle flag marking a rejected load.

Function
REQ-012 Priority per edge SHALL be: reset > load > en; with none of these active, count holds.
REQ-013 Every digit of count SHALL always lie in 0..9, and count SHALL always lie in 0..MODULUS-1.
REQ-014 Increment: when count == MODULUS-1, the next value SHALL be 0 (wrap).
REQ-015 Increment otherwise: digit 0 increments; any digit at 9 becomes 0 and carries into the next digit (ripple across all DIGITS).
REQ-016 Decrement: when count == 0, the next value SHALL be MODULUS-1 in BCD (wrap).
REQ-017 Decrement otherwise: digit 0 decrements; any digit at 0 becomes 9 and borrows from the next digit.
REQ-018 tc SHALL equal en & ((up & count == MODULUS-1) | (~up & count == 0)), with no register stage, so the next stage's en can be chained directly.
REQ-019 Load SHALL be accepted when every data digit is <= 9 and the data value is < MODULUS; count takes data at that edge.
REQ-020 Rejected load: count SHALL hold its prior value and load_err SHALL be 1 for exactly the next cycle.
REQ-021 load_err SHALL be 0 in every cycle after a non-rejected edge.
REQ-022 en SHALL be ignored in any cycle where load is asserted, whether the load is accepted or rejected.
REQ-023 tc SHALL reflect a direction change on up within the same cycle, with no state change.
REQ-024 MODULUS-1 SHALL be converted to its BCD constant at elaboration; no runtime binary-to-BCD conversion.

Reset
REQ-025 While reset is asserted at a clock edge, count SHALL become 0 and load_err SHALL become 0, overriding load and en.
REQ-026 Reset asserted mid-count SHALL take effect at the next edge; counting resumes from 0 on the first edge after reset deasserts with en = 1.
REQ-027 tc SHALL be valid purely combinationally from reset state: count = 0, so tc = en & ~up.

Verification (DIGITS=2, MODULUS=24 unless stated)
REQ-028 Reset, then en=1, up=1 for 25 cycles -> count steps 00..09, 10..19, 20..23, 00; tc=1 only while count=23.
REQ-029 Reset, en=1, up=0 -> count 00, 23, 22, 21, 20, 19 (digit 0 borrow from 0 to 9), ...; tc=1 only while count=00.
REQ-030 load=1 with data=0x15 -> count=0x15, load_err=0; load 0x24, then 0x1A -> count stays 0x15, load_err=1 for one cycle after each.
REQ-031 load=1, en=1, data=0x07 at count=0x12 -> count=0x07 (load wins); reset=1, load=1 -> count=0x00.
REQ-032 Cascade two instances (MODULUS=60, then 24); low tc drives high en; from 23:59 one enabled edge -> 00:00.
REQ-033 DIGITS=3, MODULUS=1000: increment from 0x999 -> 0x000; decrement from 0x100 -> 0x099.
